// File: rtl/calc_eval_engine.sv
// calc_eval_engine: infix evaluator fed by a number/operator token stream.
// Holds its own data and operator stacks, resolves precedence one step per cycle and hands arithmetic to an external ALU.
module calc_eval_engine #(
   parameter int W      = 32,
   parameter int DDEPTH = 8,
   parameter int ODEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         tok_valid,
   output logic         tok_ready,
   input  logic         tok_is_num,
   input  logic [2:0]   tok_op,
   input  logic [W-1:0] tok_num,
   output logic         res_valid,
   output logic [W-1:0] res_data,
   output logic [1:0]   res_err,
   output logic         al_req,
   output logic [1:0]   al_op,
   output logic [W-1:0] al_A,
   output logic [W-1:0] al_B,
   input  logic         al_done,
   input  logic [W-1:0] al_C,
   input  logic         al_err,
   output logic         busy
);
   localparam int DCW = $clog2(DDEPTH + 1);
   localparam int OCW = $clog2(ODEPTH + 1);
   localparam int DIW = $clog2(DDEPTH);
   localparam int OIW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                          OP_LP  = 3'd4, OP_RP  = 3'd5, OP_EQ  = 3'd6, OP_NEG = 3'd7;

   typedef enum logic [2:0] {X_OPND, X_OPTR, REDUCE, CALC, WAIT, DONE, SKIP} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   dstk_q [DDEPTH];
   logic [W-1:0]   dstk_d [DDEPTH];
   logic [2:0]     ostk_q [ODEPTH];
   logic [2:0]     ostk_d [ODEPTH];
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic [OCW-1:0] ocnt_q, ocnt_d;
   logic [2:0]     pend_q, pend_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   al_a_q, al_a_d, al_b_q, al_b_d;
   logic [1:0]     al_op_q, al_op_d;
   logic           res_valid_q, res_valid_d;
   logic [W-1:0]   res_data_q, res_data_d;
   logic [1:0]     res_err_q, res_err_d;

   logic           tok_fire, dfull, ofull;
   logic [DIW-1:0] dtop_i, dsec_i;
   logic [OIW-1:0] otop_i;
   logic [2:0]     otop;
   logic           opush, err, err_eq;
   logic [2:0]     opush_val;
   logic [1:0]     err_code;

   function automatic logic [1:0] prec(input logic [2:0] op);
      case (op)
         OP_NEG:         prec = 2'd3;
         OP_MUL, OP_DIV: prec = 2'd2;
         OP_ADD, OP_SUB: prec = 2'd1;
         default:        prec = 2'd0;
      endcase
   endfunction

   assign tok_fire = tok_valid && tok_ready;
   assign dfull    = (dcnt_q == DCW'(DDEPTH));
   assign ofull    = (ocnt_q == OCW'(ODEPTH));
   assign dtop_i   = dcnt_q[DIW-1:0] - DIW'(1);
   assign dsec_i   = dcnt_q[DIW-1:0] - DIW'(2);
   assign otop_i   = ocnt_q[OIW-1:0] - OIW'(1);
   assign otop     = ostk_q[otop_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= X_OPND;
         dstk_q      <= '{default: '0};
         ostk_q      <= '{default: '0};
         dcnt_q      <= '0;
         ocnt_q      <= '0;
         pend_q      <= '0;
         neg_q       <= 1'b0;
         al_a_q      <= '0;
         al_b_q      <= '0;
         al_op_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         dstk_q      <= dstk_d;
         ostk_q      <= ostk_d;
         dcnt_q      <= dcnt_d;
         ocnt_q      <= ocnt_d;
         pend_q      <= pend_d;
         neg_q       <= neg_d;
         al_a_q      <= al_a_d;
         al_b_q      <= al_b_d;
         al_op_q     <= al_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dstk_d      = dstk_q;
      ostk_d      = ostk_q;
      dcnt_d      = dcnt_q;
      ocnt_d      = ocnt_q;
      pend_d      = pend_q;
      neg_d       = neg_q;
      al_a_d      = al_a_q;
      al_b_d      = al_b_q;
      al_op_d     = al_op_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      opush       = 1'b0;
      opush_val   = OP_ADD;
      err         = 1'b0;
      err_eq      = 1'b0;
      err_code    = 2'd1;
      case (state_q)
         X_OPND: if (tok_fire) begin
            if (tok_is_num) begin
               if (dfull) begin
                  err      = 1'b1;
                  err_code = 2'd2;
               end else begin
                  dstk_d[dcnt_q[DIW-1:0]] = tok_num;
                  dcnt_d  = dcnt_q + DCW'(1);
                  state_d = X_OPTR;
               end
            end else begin
               case (tok_op)
                  OP_LP:   begin opush = 1'b1; opush_val = OP_LP;  end
                  OP_SUB:  begin opush = 1'b1; opush_val = OP_NEG; end
                  OP_ADD:  ;
                  default: begin err = 1'b1; err_eq = (tok_op == OP_EQ); end
               endcase
            end
         end
         X_OPTR: if (tok_fire) begin
            if (tok_is_num || tok_op == OP_LP || tok_op == OP_NEG) err = 1'b1;
            else begin
               pend_d  = tok_op;
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            if (ocnt_q == '0) begin
               if (pend_q == OP_RP)      err = 1'b1;
               else if (pend_q == OP_EQ) state_d = DONE;
               else begin opush = 1'b1; opush_val = pend_q; end
            end else if (otop == OP_NEG) begin
               // unary minus is computed as 0 - x and later overwrites its own operand
               al_a_d  = '0;
               al_b_d  = dstk_q[dtop_i];
               al_op_d = 2'd1;
               neg_d   = 1'b1;
               ocnt_d  = ocnt_q - OCW'(1);
               state_d = CALC;
            end else if (otop == OP_LP) begin
               if (pend_q == OP_RP) begin
                  ocnt_d  = ocnt_q - OCW'(1);
                  state_d = X_OPTR;
               end else if (pend_q == OP_EQ) begin
                  err    = 1'b1;
                  err_eq = 1'b1;
               end else begin opush = 1'b1; opush_val = pend_q; end
            end else if (pend_q == OP_RP || pend_q == OP_EQ || prec(otop) >= prec(pend_q)) begin
               if (dcnt_q < DCW'(2)) begin
                  err    = 1'b1;
                  err_eq = (pend_q == OP_EQ);
               end else begin
                  al_a_d  = dstk_q[dsec_i];
                  al_b_d  = dstk_q[dtop_i];
                  al_op_d = otop[1:0];
                  neg_d   = 1'b0;
                  ocnt_d  = ocnt_q - OCW'(1);
                  state_d = CALC;
               end
            end else begin opush = 1'b1; opush_val = pend_q; end
         end
         CALC: state_d = WAIT;
         WAIT: if (al_done) begin
            if (al_err) begin
               err      = 1'b1;
               err_code = 2'd3;
               err_eq   = (pend_q == OP_EQ);
            end else begin
               if (neg_q) dstk_d[dtop_i] = al_C;
               else begin
                  dstk_d[dsec_i] = al_C;
                  dcnt_d = dcnt_q - DCW'(1);
               end
               state_d = REDUCE;
            end
         end
         DONE: begin
            if (dcnt_q == DCW'(1)) begin
               res_valid_d = 1'b1;
               res_data_d  = dstk_q[0];
               res_err_d   = 2'd0;
               dcnt_d      = '0;
               ocnt_d      = '0;
               state_d     = X_OPND;
            end else begin
               err    = 1'b1;
               err_eq = 1'b1;
            end
         end
         SKIP: if (tok_fire && !tok_is_num && tok_op == OP_EQ) state_d = X_OPND;
         default: state_d = X_OPND;
      endcase

      // every operator push lands in X_OPND; a full stack turns it into an overflow error
      if (opush) begin
         if (ofull) begin
            err      = 1'b1;
            err_code = 2'd2;
         end else begin
            ostk_d[ocnt_q[OIW-1:0]] = opush_val;
            ocnt_d  = ocnt_q + OCW'(1);
            state_d = X_OPND;
         end
      end

      if (err) begin
         res_valid_d = 1'b1;
         res_err_d   = err_code;
         res_data_d  = '0;
         dcnt_d      = '0;
         ocnt_d      = '0;
         state_d     = err_eq ? X_OPND : SKIP;
      end

      if (clr) begin
         state_d     = X_OPND;
         dcnt_d      = '0;
         ocnt_d      = '0;
         pend_d      = '0;
         neg_d       = 1'b0;
         al_a_d      = '0;
         al_b_d      = '0;
         al_op_d     = '0;
         res_valid_d = 1'b0;
         res_data_d  = '0;
         res_err_d   = '0;
      end
   end

   always_comb begin
      tok_ready = (state_q == X_OPND) || (state_q == X_OPTR) || (state_q == SKIP);
      al_req    = (state_q == CALC);
      busy      = !((state_q == X_OPND) && (dcnt_q == '0) && (ocnt_q == '0));
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign al_op     = al_op_q;
   assign al_A      = al_a_q;
   assign al_B      = al_b_q;
endmodule

// File: tb/tb_calc_eval_engine.sv
// Directed bench for calc_eval_engine: expressions typed as strings, a behavioural ALU answering al_req.
// Instance uses ODEPTH=2 so operator-stack overflow is reachable with short expressions.
module tb_calc_eval_engine;
   logic        clk = 1'b0;
   logic        rst_n, clr, tok_valid, tok_ready, tok_is_num;
   logic [2:0]  tok_op;
   logic [31:0] tok_num;
   logic        res_valid;
   logic [31:0] res_data;
   logic [1:0]  res_err;
   logic        al_req;
   logic [1:0]  al_op;
   logic [31:0] al_A, al_B, al_C;
   logic        al_done, al_err, busy;

   int          checks = 0, errors = 0;
   int          nres = 0, nreq = 0, alu_cnt = 0, base;
   logic [1:0]  rq_op [8];
   logic [31:0] rq_a [8], rq_b [8];
   logic [31:0] cap_a, cap_b, last_data;
   logic [1:0]  cap_op, last_err;
   bit          clr_at_done = 1'b0;

   calc_eval_engine #(.W(32), .DDEPTH(8), .ODEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_num(tok_is_num),
      .tok_op(tok_op), .tok_num(tok_num),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
      .al_req(al_req), .al_op(al_op), .al_A(al_A), .al_B(al_B),
      .al_done(al_done), .al_C(al_C), .al_err(al_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: sample outputs and service the ALU on the falling edge
   task automatic tick();
      @(negedge clk);
      clr     = 1'b0;
      al_done = 1'b0;
      al_err  = 1'b0;
      if (res_valid) begin
         nres++;
         last_data = res_data;
         last_err  = res_err;
      end
      if (alu_cnt > 0) begin
         alu_cnt--;
         if (alu_cnt == 0) begin
            al_done = 1'b1;
            case (cap_op)
               2'd0: al_C = cap_a + cap_b;
               2'd1: al_C = cap_a - cap_b;
               2'd2: al_C = cap_a * cap_b;
               default: begin
                  if (cap_b == 0) begin al_err = 1'b1; al_C = '0; end
                  else al_C = $signed(cap_a) / $signed(cap_b);
               end
            endcase
            if (clr_at_done) begin clr = 1'b1; clr_at_done = 1'b0; end
         end
      end
      if (al_req) begin
         if (nreq < 8) begin rq_op[nreq] = al_op; rq_a[nreq] = al_A; rq_b[nreq] = al_B; end
         nreq++;
         cap_a = al_A; cap_b = al_B; cap_op = al_op;
         alu_cnt = 2;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input bit isnum, input logic [2:0] op, input logic [31:0] num);
      int n = 0;
      tok_valid = 1'b1; tok_is_num = isnum; tok_op = op; tok_num = num;
      while (!tok_ready && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $error("FAIL tok_ready_timeout: got 0 expected 1");
      end
      tick();
      tok_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         byte c;
         c = s[i];
         if (c >= "0" && c <= "9") send(1'b1, 3'd0, 32'(c - "0"));
         else case (c)
            "+": send(1'b0, 3'd0, '0);
            "-": send(1'b0, 3'd1, '0);
            "*": send(1'b0, 3'd2, '0);
            "/": send(1'b0, 3'd3, '0);
            "(": send(1'b0, 3'd4, '0);
            ")": send(1'b0, 3'd5, '0);
            default: send(1'b0, 3'd6, '0);
         endcase
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; clr = 1'b0; tok_valid = 1'b0; tok_is_num = 1'b0; tok_op = '0; tok_num = '0;
      al_done = 1'b0; al_err = 1'b0; al_C = '0;
      #12;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_al_req", 32'(al_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 2+3*4 : MUL issued before ADD
      base = nres; nreq = 0;
      send_str("2+3*4="); run(30);
      chk("t1_nres", 32'(nres - base), 32'd1);
      chk("t1_data", last_data, 32'd14);
      chk("t1_err", 32'(last_err), 32'd0);
      chk("t1_nreq", 32'(nreq), 32'd2);
      chk("t1_op0", 32'(rq_op[0]), 32'd2);
      chk("t1_op1", 32'(rq_op[1]), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);

      // parentheses and unary minus
      base = nres; nreq = 0;
      send_str("(2+3)*-4="); run(40);
      chk("t2_data", last_data, 32'hFFFF_FFEC);
      chk("t2_nreq", 32'(nreq), 32'd3);
      chk("t2_neg_op", 32'(rq_op[1]), 32'd1);
      chk("t2_neg_a", rq_a[1], 32'd0);
      chk("t2_neg_b", rq_b[1], 32'd4);

      base = nres;
      send_str("8-3-2="); run(30);
      chk("t3_leftassoc", last_data, 32'd3);

      // ALU error on the final EQ returns straight to X_OPND
      base = nres;
      send_str("7/0="); run(20);
      chk("t3_div0_err", 32'(last_err), 32'd3);
      chk("t3_div0_data", last_data, 32'd0);
      send_str("6="); run(10);
      chk("t3_noskip_n", 32'(nres - base), 32'd2);
      chk("t3_noskip_data", last_data, 32'd6);

      // operator stack overflow on third LP, rest of expression skipped
      base = nres; nreq = 0;
      send_str("((("); run(5);
      chk("t4_ovf_n", 32'(nres - base), 32'd1);
      chk("t4_ovf_err", 32'(last_err), 32'd2);
      send_str("1+5="); run(20);
      chk("t4_skip_n", 32'(nres - base), 32'd1);
      chk("t4_skip_req", 32'(nreq), 32'd0);
      send_str("6="); run(10);
      chk("t4_recover", last_data, 32'd6);

      // syntax errors
      base = nres;
      send_str("2)"); run(5);
      chk("t5_rp_n", 32'(nres - base), 32'd1);
      chk("t5_rp_err", 32'(last_err), 32'd1);
      chk("t5_rp_data", last_data, 32'd0);
      send_str("="); run(5);
      chk("t5_skip_n", 32'(nres - base), 32'd1);
      send_str("*"); run(3);
      chk("t5_mul_err", 32'(last_err), 32'd1);
      send_str("3="); send_str("9="); run(10);
      chk("t5_recover_n", 32'(nres - base), 32'd3);
      chk("t5_recover", last_data, 32'd9);

      // clr coincident with al_done in WAIT
      base = nres;
      clr_at_done = 1'b1;
      send_str("5+6="); run(15);
      chk("t6_clr_busy", 32'(busy), 32'd0);
      chk("t6_clr_nores", 32'(nres - base), 32'd0);
      send_str("4="); run(10);
      chk("t6_after_clr", last_data, 32'd4);

      // async reset while in CALC
      send_str("1+2=");
      n = 0;
      while (!al_req && n < 20) begin tick(); n++; end
      chk("t6_saw_req", 32'(al_req), 32'd1);
      rst_n = 1'b0;
      #1;
      alu_cnt = 0;
      chk("t6_rst_req", 32'(al_req), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_data", res_data, 32'd0);
      chk("t6_rst_a", al_A, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_str("3*3="); run(20);
      chk("t6_post_rst", last_data, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
